// File: rtl/pe_pkg.sv
// Shared definitions for the systolic PE row: command codes understood by
// the PEs and the sequencer state encoding.
package pe_pkg;

    localparam int unsigned CMD_RESET         = 0;
    localparam int unsigned CMD_TRIGGER       = 1;
    localparam int unsigned CMD_TRIGGER_LAST  = 2;
    localparam int unsigned CMD_LOAD_DATA     = 5;
    localparam int unsigned CMD_SET_CONV_MODE = 6;
    localparam int unsigned CMD_FORWARD       = 8;
    localparam int unsigned CMD_TRIGGER_BN    = 17;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        CFG,
        PRE,
        STREAM,
        FLUSH,
        DRAIN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/pe_seq_ctrl.sv
// Sequences one dot-product job through a systolic row of FP MAC PEs:
// setup commands, operand streaming, skew flush, accumulator drain.
module pe_seq_ctrl
    import pe_pkg::*;
#(
    parameter int ACLEN         = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_PE        = 4,
    parameter int MIN_DRAIN     = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [15:0]           job_len,
    input  logic                  job_preload,
    input  logic [DATA_WIDTH-1:0] job_preload_val,
    input  logic                  abort_i,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] op_data,
    input  logic [DATA_WIDTH-1:0] op_weight,
    output logic                  pe_cmd_valid,
    output logic [ACLEN:0]        pe_cmd,
    output logic [DATA_WIDTH-1:0] pe_param_1,
    output logic [DATA_WIDTH-1:0] pe_param_2,
    output logic [DATA_WIDTH-1:0] pe_preload_data,
    output logic [DATA_WIDTH-1:0] pe_data_o,
    output logic [DATA_WIDTH-1:0] pe_weight_o,
    input  logic [NUM_PE-1:0]     pe_busy_i,
    output logic                  done_o,
    output logic                  timeout_err,
    output logic [2:0]            state_o
);

    localparam int CW  = ACLEN + 1;
    localparam int FCW = (NUM_PE > 2) ? $clog2(NUM_PE) : 1;
    localparam int DCW = $clog2(DRAIN_TIMEOUT) + 1;

    seq_state_e            state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           len_q, len_d;
    logic                  pre_q, pre_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic [FCW-1:0]        fcnt_q, fcnt_d;
    logic [DCW-1:0]        dcnt_q, dcnt_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [CW-1:0]         cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] param1_q, param1_d;
    logic [DATA_WIDTH-1:0] preload_q, preload_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] weight_q, weight_d;
    logic                  tmo_q, tmo_d;
    logic                  handshake;

    // Abort suppresses the operand handshake so no operand is lost mid-abort.
    assign job_ready       = (state_q == IDLE);
    assign op_ready        = (state_q == STREAM) && (cnt_q < len_q) && !abort_i;
    assign handshake       = op_valid && op_ready;
    assign done_o          = (state_q == DONE) && !abort_i;
    assign timeout_err     = tmo_q;
    assign state_o         = state_q;
    assign pe_cmd_valid    = cmd_valid_q;
    assign pe_cmd          = cmd_q;
    assign pe_param_1      = param1_q;
    assign pe_param_2      = '0;
    assign pe_preload_data = preload_q;
    assign pe_data_o       = data_q;
    assign pe_weight_o     = weight_q;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            pre_q       <= 1'b0;
            val_q       <= '0;
            fcnt_q      <= '0;
            dcnt_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            param1_q    <= '0;
            preload_q   <= '0;
            data_q      <= '0;
            weight_q    <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            pre_q       <= pre_d;
            val_q       <= val_d;
            fcnt_q      <= fcnt_d;
            dcnt_q      <= dcnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            param1_q    <= param1_d;
            preload_q   <= preload_d;
            data_q      <= data_d;
            weight_q    <= weight_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        pre_d       = pre_q;
        val_d       = val_q;
        fcnt_d      = fcnt_q;
        dcnt_d      = dcnt_q;
        cmd_valid_d = 1'b0;
        cmd_d       = cmd_q;
        param1_d    = param1_q;
        preload_d   = preload_q;
        data_d      = data_q;
        weight_d    = weight_q;
        tmo_d       = 1'b0;

        if (abort_i && (state_q != IDLE)) begin
            state_d     = IDLE;
            cmd_valid_d = 1'b1;
            cmd_d       = CW'(CMD_RESET);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (job_valid) begin
                        len_d   = job_len;
                        pre_d   = job_preload;
                        val_d   = job_preload_val;
                        cnt_d   = '0;
                        state_d = (job_len == 16'd0) ? DONE : CLR;
                    end
                end
                CLR: begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = CW'(CMD_RESET);
                    state_d     = CFG;
                end
                CFG: begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = CW'(CMD_SET_CONV_MODE);
                    param1_d    = DATA_WIDTH'(len_q);
                    state_d     = pre_q ? PRE : STREAM;
                end
                PRE: begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = CW'(CMD_LOAD_DATA);
                    preload_d   = val_q;
                    state_d     = STREAM;
                end
                STREAM: begin
                    if (handshake) begin
                        cmd_valid_d = 1'b1;
                        data_d      = op_data;
                        weight_d    = op_weight;
                        cnt_d       = cnt_q + 16'd1;
                        if (cnt_q == len_q - 16'd1) begin
                            cmd_d   = CW'(CMD_TRIGGER_LAST);
                            fcnt_d  = '0;
                            dcnt_d  = '0;
                            state_d = (NUM_PE > 1) ? FLUSH : DRAIN;
                        end else begin
                            cmd_d = CW'(CMD_TRIGGER);
                        end
                    end
                end
                FLUSH: begin
                    // Zero operands push the skewed partial sums out of the row.
                    cmd_valid_d = 1'b1;
                    cmd_d       = CW'(CMD_FORWARD);
                    data_d      = '0;
                    weight_d    = '0;
                    fcnt_d      = fcnt_q + FCW'(1);
                    if (fcnt_q == FCW'(NUM_PE - 2)) begin
                        dcnt_d  = '0;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if ((dcnt_q >= DCW'(MIN_DRAIN)) && (pe_busy_i == '0)) begin
                        state_d = DONE;
                    end else if (dcnt_q == DCW'(DRAIN_TIMEOUT - 1)) begin
                        tmo_d       = 1'b1;
                        cmd_valid_d = 1'b1;
                        cmd_d       = CW'(CMD_RESET);
                        state_d     = IDLE;
                    end else begin
                        dcnt_d = dcnt_q + DCW'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: table of jobs checked against a
// cycle-level reference of the command bus, plus abort and reset sequences.
module tb_pe_seq_ctrl;
    import pe_pkg::*;

    localparam int ACLEN         = 8;
    localparam int DW            = 32;
    localparam int NUM_PE        = 4;
    localparam int MIN_DRAIN     = 16;
    localparam int DRAIN_TIMEOUT = 1024;
    localparam int BUDGET        = 1400;

    typedef struct {
        int          len;
        bit          pre;
        logic [31:0] val;
        int          mode;
        logic [3:0]  busy;
        int          rel;
        int          expDone;
        int          expTmo;
    } job_vec_t;

    typedef struct {
        int          cmd;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] pre;
        logic [31:0] data;
        logic [31:0] wt;
        int          cyc;
    } cmd_rec_t;

    logic            clk_i = 1'b0;
    logic            rst = 1'b1;
    logic            job_valid = 1'b0;
    logic            job_ready;
    logic [15:0]     job_len = '0;
    logic            job_preload = 1'b0;
    logic [DW-1:0]   job_preload_val = '0;
    logic            abort_i = 1'b0;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [DW-1:0]   op_data = '0;
    logic [DW-1:0]   op_weight = '0;
    logic            pe_cmd_valid;
    logic [ACLEN:0]  pe_cmd;
    logic [DW-1:0]   pe_param_1;
    logic [DW-1:0]   pe_param_2;
    logic [DW-1:0]   pe_preload_data;
    logic [DW-1:0]   pe_data_o;
    logic [DW-1:0]   pe_weight_o;
    logic [NUM_PE-1:0] pe_busy_i = '0;
    logic            done_o;
    logic            timeout_err;
    logic [2:0]      state_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int jobStart, streamStart, relAbs;

    cmd_rec_t    actQ[$];
    int          doneQ[$];
    int          tmoQ[$];
    int          hsQ[$];
    logic [31:0] opsD[$];
    logic [31:0] opsW[$];
    bit          validLog[$];

    pe_seq_ctrl #(
        .ACLEN(ACLEN), .DATA_WIDTH(DW), .NUM_PE(NUM_PE),
        .MIN_DRAIN(MIN_DRAIN), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
        .job_preload(job_preload), .job_preload_val(job_preload_val),
        .abort_i(abort_i),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_weight(op_weight),
        .pe_cmd_valid(pe_cmd_valid), .pe_cmd(pe_cmd),
        .pe_param_1(pe_param_1), .pe_param_2(pe_param_2),
        .pe_preload_data(pe_preload_data),
        .pe_data_o(pe_data_o), .pe_weight_o(pe_weight_o),
        .pe_busy_i(pe_busy_i), .done_o(done_o), .timeout_err(timeout_err),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Bus monitor: everything observed mid-cycle, tagged with the cycle number.
    always @(negedge clk_i) begin : monitor
        cmd_rec_t r;
        if (pe_cmd_valid) begin
            r.cmd  = int'(pe_cmd);
            r.p1   = pe_param_1;
            r.p2   = pe_param_2;
            r.pre  = pe_preload_data;
            r.data = pe_data_o;
            r.wt   = pe_weight_o;
            r.cyc  = cyc;
            actQ.push_back(r);
        end
        if (done_o) doneQ.push_back(cyc);
        if (timeout_err) tmoQ.push_back(cyc);
        if (op_valid && op_ready) hsQ.push_back(cyc);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic cmd_rec_t mk(input int cmd, input logic [31:0] p1, input logic [31:0] pre,
                                    input logic [31:0] d, input logic [31:0] w, input int c);
        cmd_rec_t r;
        r.cmd = cmd; r.p1 = p1; r.p2 = '0; r.pre = pre; r.data = d; r.wt = w; r.cyc = c;
        return r;
    endfunction

    function automatic bit validFor(input int mode, input int w);
        int pat[7];
        pat = '{1, 0, 0, 1, 1, 0, 1};
        if (mode == 0) return 1'b1;
        if (mode == 1) return (w >= streamStart) ? bit'(pat[(w - streamStart) % 7]) : 1'b0;
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic clearLogs();
        actQ.delete(); doneQ.delete(); tmoQ.delete(); hsQ.delete();
    endtask

    task automatic applyStimulus(input job_vec_t v);
        int idx;
        int tail;
        bit hs;
        clearLogs();
        opsD.delete(); opsW.delete(); validLog.delete();
        for (int i = 0; i < v.len; i++) begin
            opsD.push_back($urandom);
            opsW.push_back($urandom);
        end
        @(posedge clk_i); #1;
        jobStart    = cyc;
        streamStart = jobStart + 3 + (v.pre ? 1 : 0);
        relAbs      = (v.rel < 0) ? -1 : jobStart + v.rel;
        job_valid       = 1'b1;
        job_len         = 16'(v.len);
        job_preload     = v.pre;
        job_preload_val = v.val;
        idx  = 0;
        tail = 0;
        for (int c = 0; c < BUDGET; c++) begin
            op_valid  = validFor(v.mode, cyc);
            validLog.push_back(op_valid);
            op_data   = (idx < v.len) ? opsD[idx] : $urandom;
            op_weight = (idx < v.len) ? opsW[idx] : $urandom;
            pe_busy_i = (relAbs < 0 || cyc < relAbs) ? v.busy : '0;
            @(negedge clk_i);
            hs = op_valid && op_ready;
            @(posedge clk_i); #1;
            job_valid = 1'b0;
            if (hs) idx++;
            if (doneQ.size() + tmoQ.size() > 0) tail++;
            if (tail == 3) break;
        end
        if (tail < 3) checkOutput("job_end_bound", 0, 1);
        op_valid  = 1'b0;
        pe_busy_i = '0;
    endtask

    task automatic checkJob(input job_vec_t v, input int row);
        cmd_rec_t expQ[$];
        int expHs[$];
        int last, drainStart, clear, expDoneCyc, expTmoCyc, n;
        expDoneCyc = -1;
        expTmoCyc  = -1;
        for (int w = streamStart - jobStart; w < validLog.size() && expHs.size() < v.len; w++)
            if (validLog[w]) expHs.push_back(jobStart + w);
        checkOutput($sformatf("job%0d_handshakes", row), hsQ.size(), v.len);
        if (v.len == 0) begin
            expDoneCyc = jobStart + 1;
        end else begin
            expQ.push_back(mk(CMD_RESET, 0, 0, 0, 0, jobStart + 2));
            expQ.push_back(mk(CMD_SET_CONV_MODE, v.len, 0, 0, 0, jobStart + 3));
            if (v.pre) expQ.push_back(mk(CMD_LOAD_DATA, 0, v.val, 0, 0, jobStart + 4));
            for (int i = 0; i < v.len; i++)
                expQ.push_back(mk((i == v.len - 1) ? CMD_TRIGGER_LAST : CMD_TRIGGER, 0, 0,
                                  opsD[i], opsW[i], (i < expHs.size()) ? expHs[i] + 1 : -1));
            last = expQ[expQ.size() - 1].cyc;
            for (int k = 1; k < NUM_PE; k++) expQ.push_back(mk(CMD_FORWARD, 0, 0, 0, 0, last + k));
            drainStart = last + NUM_PE - 1;
            clear = drainStart + MIN_DRAIN;
            if (v.busy != 0) begin
                if (relAbs < 0) clear = drainStart + DRAIN_TIMEOUT;
                else if (relAbs > clear) clear = relAbs;
            end
            if (clear <= drainStart + DRAIN_TIMEOUT - 1) begin
                expDoneCyc = clear + 1;
            end else begin
                expTmoCyc = drainStart + DRAIN_TIMEOUT;
                expQ.push_back(mk(CMD_RESET, 0, 0, 0, 0, expTmoCyc));
            end
        end
        checkOutput($sformatf("job%0d_cmd_count", row), actQ.size(), expQ.size());
        n = (actQ.size() < expQ.size()) ? actQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("job%0d_cmd%0d_code", row, i), actQ[i].cmd, expQ[i].cmd);
            checkOutput($sformatf("job%0d_cmd%0d_cycle", row, i), actQ[i].cyc, expQ[i].cyc);
            checkOutput($sformatf("job%0d_cmd%0d_param2", row, i), actQ[i].p2, 0);
            if (expQ[i].cmd == CMD_SET_CONV_MODE)
                checkOutput($sformatf("job%0d_cmd%0d_param1", row, i), actQ[i].p1, expQ[i].p1);
            if (expQ[i].cmd == CMD_LOAD_DATA)
                checkOutput($sformatf("job%0d_cmd%0d_preload", row, i), actQ[i].pre, expQ[i].pre);
            if (expQ[i].cmd == CMD_TRIGGER || expQ[i].cmd == CMD_TRIGGER_LAST || expQ[i].cmd == CMD_FORWARD) begin
                checkOutput($sformatf("job%0d_cmd%0d_data", row, i), actQ[i].data, expQ[i].data);
                checkOutput($sformatf("job%0d_cmd%0d_weight", row, i), actQ[i].wt, expQ[i].wt);
            end
        end
        checkOutput($sformatf("job%0d_done_count", row), doneQ.size(), v.expDone);
        if (v.expDone > 0 && doneQ.size() > 0)
            checkOutput($sformatf("job%0d_done_cycle", row), doneQ[0], expDoneCyc);
        checkOutput($sformatf("job%0d_tmo_count", row), tmoQ.size(), v.expTmo);
        if (v.expTmo > 0 && tmoQ.size() > 0)
            checkOutput($sformatf("job%0d_tmo_cycle", row), tmoQ[0], expTmoCyc);
        @(negedge clk_i);
        checkOutput($sformatf("job%0d_ready_after", row), job_ready, 1);
        checkOutput($sformatf("job%0d_state_after", row), state_o, 0);
    endtask

    initial begin
        job_vec_t vecs[$];
        job_vec_t v;
        int p, trig;

        vecs.push_back('{3, 1'b0, 32'h0,        0, 4'h0,  0, 1, 0});
        vecs.push_back('{2, 1'b1, 32'h3F800000, 0, 4'h0,  0, 1, 0});
        vecs.push_back('{4, 1'b0, 32'h0,        1, 4'h0,  0, 1, 0});
        vecs.push_back('{0, 1'b1, 32'h12345678, 0, 4'h0,  0, 1, 0});
        vecs.push_back('{5, 1'b1, 32'hC0490FDB, 2, 4'h5, 60, 1, 0});
        vecs.push_back('{3, 1'b0, 32'h0,        0, 4'h2, -1, 0, 1});
        vecs.push_back('{1, 1'b0, 32'h0,        0, 4'h8,  5, 1, 0});
        vecs.push_back('{1, 1'b1, 32'h40000000, 2, 4'h0,  0, 1, 0});
        for (int i = 0; i < 6; i++) begin
            v.len = $urandom_range(1, 12); v.pre = bit'($urandom_range(0, 1)); v.val = $urandom;
            v.mode = 2; v.busy = 4'($urandom_range(0, 15)); v.rel = $urandom_range(0, 60);
            v.expDone = 1; v.expTmo = 0;
            vecs.push_back(v);
        end

        $display("[TB] reset check");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_job_ready", job_ready, 1);
        checkOutput("rst_state", state_o, 0);
        checkOutput("rst_cmd_valid", pe_cmd_valid, 0);
        checkOutput("rst_cmd", pe_cmd, 0);
        checkOutput("rst_op_ready", op_ready, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        checkOutput("rst_data", {pe_data_o, pe_weight_o}, 0);
        @(posedge clk_i); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            $display("[TB] job %0d len=%0d pre=%0d mode=%0d", i, vecs[i].len, vecs[i].pre, vecs[i].mode);
            applyStimulus(vecs[i]);
            checkJob(vecs[i], i);
        end

        $display("[TB] abort sequence");
        clearLogs();
        @(posedge clk_i); #1; abort_i = 1'b1;
        @(posedge clk_i); #1; abort_i = 1'b0;
        @(negedge clk_i);
        checkOutput("abort_idle_no_cmd", actQ.size(), 0);
        checkOutput("abort_idle_ready", job_ready, 1);
        @(posedge clk_i); #1;
        p = cyc;
        job_valid = 1'b1; job_len = 16'd6; job_preload = 1'b0;
        op_valid = 1'b1; op_data = 32'h1111_0000; op_weight = 32'h2222_0000;
        @(posedge clk_i); #1; job_valid = 1'b0;
        @(posedge clk_i); #1; job_valid = 1'b1; job_len = 16'd0;
        @(posedge clk_i); #1; job_valid = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1; abort_i = 1'b1;
        @(negedge clk_i);
        checkOutput("abort_gates_op_ready", op_ready, 0);
        @(posedge clk_i); #1; abort_i = 1'b0; op_valid = 1'b0;
        @(negedge clk_i);
        checkOutput("abort_reset_valid", pe_cmd_valid, 1);
        checkOutput("abort_reset_code", pe_cmd, CMD_RESET);
        checkOutput("abort_state_idle", state_o, 0);
        checkOutput("abort_job_ready", job_ready, 1);
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        trig = 0;
        foreach (actQ[i]) if (actQ[i].cmd == CMD_TRIGGER || actQ[i].cmd == CMD_TRIGGER_LAST) trig++;
        checkOutput("abort_trigger_count", trig, 2);
        checkOutput("abort_cmd_count", actQ.size(), 5);
        if (actQ.size() == 5) checkOutput("abort_reset_cycle", actQ[4].cyc, p + 6);
        checkOutput("abort_no_done", doneQ.size(), 0);

        $display("[TB] reset mid-flush sequence");
        clearLogs();
        @(posedge clk_i); #1;
        p = cyc;
        job_valid = 1'b1; job_len = 16'd2; job_preload = 1'b0;
        op_valid = 1'b1; op_data = 32'hABCD_0001; op_weight = 32'h0000_BEEF;
        repeat (6) begin
            @(posedge clk_i); #1; job_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk_i);
        checkOutput("flush_forward_seen", pe_cmd, CMD_FORWARD);
        @(negedge clk_i);
        checkOutput("rstmid_cmd_valid", pe_cmd_valid, 0);
        checkOutput("rstmid_cmd", pe_cmd, 0);
        checkOutput("rstmid_param1", pe_param_1, 0);
        checkOutput("rstmid_data", {pe_data_o, pe_weight_o}, 0);
        checkOutput("rstmid_job_ready", job_ready, 1);
        checkOutput("rstmid_state", state_o, 0);
        @(posedge clk_i); #1; rst = 1'b0; op_valid = 1'b0;
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        trig = 0;
        foreach (actQ[i]) if (actQ[i].cyc >= p + 7) trig++;
        checkOutput("rstmid_no_cmd_after", trig, 0);
        checkOutput("rstmid_no_done", doneQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
- Sequences one dot-product job through a systolic row of NUM_PE floating-point MAC PEs. It drives the shared PE command bus (pe_cmd_valid/pe_cmd/params) and the row-0 data/weight inputs.
- Accepts a job descriptor from the layer scheduler and streams operands from the operand buffer.
- Flushes the systolic skew, waits for the accumulators to drain, then signals completion.

Parameters:
- ACLEN, 8, PE command width minus 1 (pe_cmd is ACLEN+1 bits).
- DATA_WIDTH, 32, operand / FP32 word width.
- NUM_PE, 4, PEs in the row; sets the flush length.
- MIN_DRAIN, 16, minimum DRAIN cycles before busy is sampled (covers MAC + ACC latency).
- DRAIN_TIMEOUT, 1024, maximum DRAIN cycles before error.

Ports:
- clk_i  in  1  clock
- rst  in  1  reset: synchronous, active-high
- job_valid  in  1  job descriptor valid
- job_ready  out  1  controller idle, accepts job
- job_len  in  16  number of MAC operand pairs
- job_preload  in  1  issue LOAD_DATA before streaming
- job_preload_val  in  DATA_WIDTH  accumulator preload value
- abort_i  in  1  abort the current job
- op_valid  in  1  operand pair valid
- op_ready  out  1  operand pair accepted
- op_data  in  DATA_WIDTH  data operand
- op_weight  in  DATA_WIDTH  weight operand
- pe_cmd_valid  out  1  PE command strobe (registered)
- pe_cmd  out  ACLEN+1  PE command code
- pe_param_1  out  DATA_WIDTH  command param 1
- pe_param_2  out  DATA_WIDTH  command param 2 (always 0)
- pe_preload_data  out  DATA_WIDTH  LOAD_DATA value
- pe_data_o  out  DATA_WIDTH  data to PE row input
- pe_weight_o  out  DATA_WIDTH  weight to PE row input
- pe_busy_i  in  NUM_PE  per-PE busy
- done_o  out  1  one-cycle job-complete pulse
- timeout_err  out  1  one-cycle drain-timeout pulse
- state_o  out  3  current state (debug)

Behaviour:
- Reset: all outputs 0 except job_ready=1; state IDLE; counters 0. A reset mid-job drops the job immediately and issues no PE command.
- All pe_* outputs are registered. A command appears on the bus the cycle after the state/handshake that causes it. pe_cmd_valid is high exactly one cycle per command.
- IDLE: job_ready=1. On job_valid, latch len/preload/val.
  - len==0: go to DONE (no PE commands).
  - otherwise: go to CLR.
- CLR (1 cycle): emit RESET (0). Go to CFG.
- CFG (1 cycle): emit SET_CONV_MODE (6), pe_param_1=len. Go to PRE if preload, else STREAM.
- PRE (1 cycle): emit LOAD_DATA (5), pe_preload_data=val. Go to STREAM.
- STREAM: op_ready=1 while cnt<len.
  - Each op_valid&&op_ready emits TRIGGER (1) next cycle with pe_data_o/pe_weight_o=operands, then cnt++.
  - The handshake with cnt==len-1 emits TRIGGER_LAST (2) instead; op_ready drops the next cycle; go to FLUSH.
  - Cycles with no handshake: pe_cmd_valid=0; data outputs hold.
- FLUSH: emit NUM_PE-1 consecutive FORWARD (8) commands with pe_data_o=pe_weight_o=0. Go to DRAIN. If NUM_PE==1, skip straight to DRAIN.
- DRAIN: cycle counter dcnt from 0.
  - When dcnt>=MIN_DRAIN and pe_busy_i==0: go to DONE.
  - When dcnt==DRAIN_TIMEOUT-1 and not yet clear: pulse timeout_err, emit RESET, go to IDLE.
- DONE (1 cycle): done_o=1. Go to IDLE; job_ready returns next cycle.
- abort_i in any state other than IDLE: next cycle emit RESET, go to IDLE, no done_o. abort_i takes priority over every transition in that cycle. abort_i in IDLE is ignored.
- job_valid while not IDLE: ignored (job_ready=0).
- cnt is 16-bit; len=65535 completes with no wrap.

Decomposition:
- pe_pkg:
  - PE command localparams: RESET=0, TRIGGER=1, TRIGGER_LAST=2, LOAD_DATA=5, SET_CONV_MODE=6, FORWARD=8, TRIGGER_BN=17.
  - State enum: IDLE, CLR, CFG, PRE, STREAM, FLUSH, DRAIN, DONE.
  - The PE and this block both import it.
- No sub-module. Single FSM plus cnt/fcnt/dcnt counters.

Test Plan:
- len=3, preload=0, op_valid constant.
  - Required bus sequence: RESET, SET_CONV_MODE(param_1=3), TRIGGER, TRIGGER, TRIGGER_LAST, FORWARD x3.
  - Then DRAIN; done_o pulses once after busy clears and ≥16 cycles.
- len=2, preload=1, val=0x3F800000.
  - LOAD_DATA with pe_preload_data=0x3F800000 appears between SET_CONV_MODE and the first TRIGGER.
- len=4 with op_valid toggled 1,0,0,1,1,0,1.
  - Exactly 4 trigger commands, gap-aligned to the handshakes; the last one is TRIGGER_LAST; operand values pass through unchanged.
- len=0 -> done_o one cycle after acceptance, pe_cmd_valid never asserted.
- Hold pe_busy_i=4'b0010 through DRAIN -> timeout_err at dcnt=1023, RESET emitted, job_ready=1, no done_o.
- Assert abort_i during STREAM after 2 triggers -> RESET next cycle, state IDLE, no done_o. Repeat with rst mid-FLUSH -> all outputs 0, job_ready=1.
